// File: rtl/binary_string_serializer_pkg.sv
// Shared types and defaults for the binary-string serializer and its helpers.
package binary_string_serializer_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_MODULUS = 7;
    localparam int unsigned DEF_REM_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/binary_string_serializer_mod_accumulator.sv
// Serial MSB-first running remainder: r <= (2r + bit) mod MODULUS, one bit per clock.
// The remainder after the current bit is offered combinationally so a caller can
// capture the final value on the same edge that consumes the last bit.
module binary_string_serializer_mod_accumulator
    import binary_string_serializer_pkg::*;
#(
    parameter int unsigned MODULUS = DEF_MODULUS,
    parameter int unsigned REM_W   = DEF_REM_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic             i_bit,
    output logic [REM_W-1:0] o_remainder_c
);

    localparam int unsigned SUM_W = REM_W + 1;

    logic [REM_W-1:0] r_rem;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_mod;
    logic [SUM_W-1:0] w_red;

    // 2r + bit is below 2*MODULUS, so one conditional subtract reduces it
    always_comb begin
        w_sum = {r_rem, i_bit};
        w_mod = SUM_W'(MODULUS);
        w_red = (w_sum >= w_mod) ? (w_sum - w_mod) : w_sum;
    end

    assign o_remainder_c = REM_W'(w_red);

    // Remainder register: clear wins over a step
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_rem <= '0;
        end else if (i_enable) begin
            r_rem <= REM_W'(w_red);
        end
    end

endmodule

// File: rtl/binary_string_serializer.sv
// Transmit side of the serial binary-string link: frame-clear pulse, then the
// word MSB-first on String, then a Done pulse with the word's remainder.
module binary_string_serializer
    import binary_string_serializer_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MODULUS = DEF_MODULUS,
    parameter int unsigned REM_W   = DEF_REM_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Load_Valid,
    input  logic [WIDTH-1:0] Load_Data,
    output logic             Ready,
    output logic             String,
    output logic             Frame_Reset,
    output logic             Busy,
    output logic             Done,
    output logic [REM_W-1:0] Expected_Remainder,
    output logic             Expected_Divisible
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_shifting;
    logic             w_last_bit;
    logic [REM_W-1:0] w_rem_next;

    assign w_accept   = (r_state == ST_IDLE) && Load_Valid;
    assign w_shifting = (r_state == ST_SHIFT);
    assign w_last_bit = w_shifting && (r_count == CNT_W'(WIDTH - 1));

    // Outputs decoded from state and the shift register only
    assign Ready       = (r_state == ST_IDLE);
    assign Frame_Reset = (r_state == ST_CLEAR);
    assign Busy        = (r_state == ST_CLEAR) || w_shifting;
    assign Done        = (r_state == ST_DONE);
    assign String      = w_shifting && r_shift[WIDTH-1];

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (Load_Valid) w_state_next = ST_CLEAR;
            ST_CLEAR: w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last_bit) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Word capture, shifting, bit count and held result
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_shift            <= '0;
            r_count            <= '0;
            Expected_Remainder <= '0;
            Expected_Divisible <= 1'b0;
        end else if (w_accept) begin
            r_shift <= Load_Data;
            r_count <= '0;
        end else if (w_shifting) begin
            r_shift <= r_shift << 1;
            r_count <= r_count + CNT_W'(1);
            if (w_last_bit) begin
                Expected_Remainder <= w_rem_next;
                Expected_Divisible <= (w_rem_next == '0);
            end
        end
    end

    // Running remainder of the bits already sent
    binary_string_serializer_mod_accumulator #(
        .MODULUS (MODULUS),
        .REM_W   (REM_W)
    ) u_mod_acc (
        .i_clk         (Clock),
        .i_rst         (Reset),
        .i_clear       (w_accept),
        .i_enable      (w_shifting),
        .i_bit         (r_shift[WIDTH-1]),
        .o_remainder_c (w_rem_next)
    );

endmodule

// File: doc/binary_string_serializer.md
Name: binary_string_serializer

Overview:
Transmit end of the serial binary-string interface. Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on String, one bit per Clock. Before each word it emits a one-cycle Frame_Reset pulse so a downstream serial mod-7 divisibility checker starts from remainder 0. It tracks the running remainder of the word itself, so a bench or system can compare it against the downstream checker.

Parameters:
WIDTH, 8, bits per word; legal range 1..32.
MODULUS, 7, divisor for the expected-remainder tracker; legal range 2..8.
REM_W, 3, remainder width; must satisfy 2^REM_W >= MODULUS.

Ports:
Clock  input  1  single clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Load_Valid  input  1  Load_Data is valid this cycle.
Load_Data  input  WIDTH  word to transmit; bit WIDTH-1 is sent first.
Ready  output  1  high only in IDLE; a word is accepted on an edge where Load_Valid & Ready.
String  output  1  serial data bit toward the checker.
Frame_Reset  output  1  one-cycle start-of-word clear toward the checker's Reset.
Busy  output  1  high in CLEAR and SHIFT.
Done  output  1  one-cycle pulse after the last bit has been sent.
Expected_Remainder  output  REM_W  Load_Data mod MODULUS; valid from Done, held until the next accept.
Expected_Divisible  output  1  (Expected_Remainder == 0); valid and held the same way.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; ports named Clock and Reset.
- Reset values: state IDLE, String 0, Frame_Reset 0, Busy 0, Done 0, Expected_Remainder 0, Expected_Divisible 0. Ready is therefore 1 after reset.
- All outputs are registered or decoded directly from state. There is no combinational path from Load_Valid or Load_Data to any output.
- FSM states: IDLE, CLEAR, SHIFT, DONE.
  - IDLE: Ready=1. On Load_Valid, capture Load_Data into the shift register, clear the bit counter and running remainder, go to CLEAR.
  - CLEAR: exactly one cycle. Frame_Reset=1, String=0, Busy=1. Go to SHIFT.
  - SHIFT: exactly WIDTH cycles. String = current MSB of the shift register, Busy=1, shift left by one each cycle.
    - Running remainder update: r <= (2r + bit); subtract MODULUS once if the result is >= MODULUS. Compute in REM_W+1 bits. No divider or % operator.
    - After bit WIDTH is sent, go to DONE.
  - DONE: exactly one cycle. Done=1, String=0, Busy=0, Ready=0. Expected_Remainder and Expected_Divisible are updated on entry to DONE. Go to IDLE.
- Latency: word accepted at edge k. Frame_Reset is high in cycle k+1. Bits occupy cycles k+2 .. k+1+WIDTH. Done is high in cycle k+2+WIDTH.
- Back-to-back words: the next accept can occur at the earliest one cycle after DONE. Word period is WIDTH+3 cycles.
- Load_Valid while Ready=0 is ignored; Load_Data is not sampled and state is unchanged.
- String is 0 in IDLE, CLEAR and DONE.
- WIDTH=1: SHIFT lasts one cycle.
- Reset asserted in any state wins over everything. Next cycle is IDLE with the reset values above; a partial word is discarded and Done is not pulsed.
- Reset together with Load_Valid: reset wins and the word is not accepted.

Decomposition:
- Shared package: state encoding constants (IDLE/CLEAR/SHIFT/DONE), default MODULUS=7, REM_W=3.
- One natural sub-module, mod_accumulator: REM_W-bit running remainder with clear/enable/bit inputs, implementing the r update above. It is reusable on the receive side.
- Bit counter width: clog2(WIDTH+1).

Test Plan:
1. Reset for 2 cycles, then release -> Ready=1, String=0, Frame_Reset=0, Busy=0, Done=0, Expected_Remainder=0.
2. Load 8'd220 (11011100) -> Frame_Reset for 1 cycle, then String = 1,1,0,1,1,1,0,0 on consecutive cycles; Done at k+10; Expected_Remainder=3, Expected_Divisible=0.
3. Load 8'd14, then 8'd0 at the first Ready -> first word gives Remainder 0 / Divisible 1. Second accept occurs exactly 11 cycles after the first (k+11), with all-zero String and Remainder 0 / Divisible 1.
4. Load 8'hFF, then pulse Load_Valid with 8'h00 during SHIFT -> second word ignored; String is eight 1s; Expected_Remainder=3.
5. Load 8'd13 and assert Reset during the 4th bit -> next cycle IDLE, String=0, no Done pulse. Reload 8'd13 afterwards -> Expected_Remainder=6.
6. Loopback: connect String/Frame_Reset to the mod-7 divisibility checker's String/Reset and send 200 random words. In each Done cycle, the checker's Remainder and Divisible must equal Expected_Remainder and Expected_Divisible.
